bmp_arbiter_nch: RTL

//  N-slave successor of the two-slave BMP arbiter. Round-robin grants one slave per packet and forwards its beats
//  to the processor. Processor results are buffered in an internal output FIFO and streamed to master 0.

---
 rtl/bmp_arbiter_nch.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/bmp_arbiter_nch.sv
// rtl/bmp_arbiter_nch.sv - N-slave round-robin packet arbiter with credit-protected output FIFO
//
// Grants one slave per packet and forwards its beats to the processor.
// Processor results are buffered in an output FIFO and streamed to master 0.
// A credit check keeps the FIFO from ever overflowing.
//
// Build option: define BMP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
// Leave it undefined (default) for round-robin arbitration.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   slv_mode              per-slave mode; slave i at [2i+1:2i]
//   slv_data_valid        per-slave beat valid
//   slv_data              per-slave data, slice i
//   slv_data_proc         per-slave processing byte, slice i
//   slv_ready             per-slave ready (one-hot or zero)
//   data_to_processor     registered beat to processor
//   scheduler_2_proc_vld  data_to_processor valid, one cycle per beat
//   mode, data_proc       granted slave mode/proc byte, held for the grant
//   data_from_processor   processor result
//   vld_pr                processor result valid
//   done                  pulse: all results of the grant received
//   mstr0_ready           master accepts the FIFO head
//   data_to_master        FIFO head (zero when empty)
//   mstr0_data_valid      FIFO not empty
//   mstr0_cmplt           pulse: packet fully delivered
//   ovf_err               sticky: result arrived while the FIFO was full
module bmp_arbiter_nch #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int NUM_SLV       = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int BURST_LEN     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*NUM_SLV-1:0]         slv_mode,
  input  logic [NUM_SLV-1:0]           slv_data_valid,
  input  logic [DATA_BUS_SIZE*NUM_SLV-1:0] slv_data,
  input  logic [8*NUM_SLV-1:0]         slv_data_proc,
  output logic [NUM_SLV-1:0]           slv_ready,
  output logic [DATA_BUS_SIZE-1:0]     data_to_processor,
  output logic                         scheduler_2_proc_vld,
  output logic [1:0]                   mode,
  output logic [7:0]                   data_proc,
  input  logic [DATA_BUS_SIZE-1:0]     data_from_processor,
  input  logic                         vld_pr,
  output logic                         done,
  input  logic                         mstr0_ready,
  output logic [DATA_BUS_SIZE-1:0]     data_to_master,
  output logic                         mstr0_data_valid,
  output logic                         mstr0_cmplt,
  output logic                         ovf_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_CMPLT} state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
`ifndef BMP_ARB_FIXED_PRIO_EN
  logic [GW-1:0]            rr_q, rr_d;
`endif
  logic [CW-1:0]            out_q, out_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               beat_q, beat_d;
  logic [AW-1:0]            wp_q, wp_d, rp_q, rp_d;
  logic [DATA_BUS_SIZE-1:0] dtp_q, dtp_d;
  logic                     pvld_q, pvld_d;
  logic [1:0]               mode_q, mode_d;
  logic [7:0]               dproc_q, dproc_d;
  logic                     done_q, done_d;
  logic                     cmplt_q, cmplt_d;
  logic                     ovf_q, ovf_d;
  logic [DATA_BUS_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic          credit_ok, g_valid, accept, proc_in, full, push, pop, found;
  logic [GW-1:0] pick;

  // Arbitration: first requester at or after the start index, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      int t;
      logic [GW-1:0] idx;
`ifdef BMP_ARB_FIXED_PRIO_EN
      t = k;
`else
      t = (int'(rr_q) + k) % NUM_SLV;
`endif
      idx = GW'(t);
      if (!found && slv_data_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Results in flight count against FIFO space so the FIFO cannot overflow.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_L;
  assign g_valid   = slv_data_valid[grant_q];
  assign accept    = (state_q == S_XFER) && credit_ok && g_valid;
  assign proc_in   = ((state_q == S_XFER) || (state_q == S_DRAIN)) && vld_pr && (out_q != '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign push      = proc_in && !full;
  assign pop       = (cnt_q != '0) && mstr0_ready;

  always_comb begin
    slv_ready = '0;
    if ((state_q == S_XFER) && credit_ok) slv_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifndef BMP_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    beat_d  = beat_q;
    dtp_d   = dtp_q;
    pvld_d  = 1'b0;
    mode_d  = mode_q;
    dproc_d = dproc_q;
    done_d  = 1'b0;
    cmplt_d = 1'b0;
    ovf_d   = ovf_q | (proc_in & full);
    wp_d    = push ? wp_q + AW'(1) : wp_q;
    rp_d    = pop  ? rp_q + AW'(1) : rp_q;

    case ({accept, proc_in})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          mode_d  = slv_mode[2*pick +: 2];
          dproc_d = slv_data_proc[8*pick +: 8];
          beat_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (accept) begin
          dtp_d  = slv_data[grant_q*DATA_BUS_SIZE +: DATA_BUS_SIZE];
          pvld_d = 1'b1;
          beat_d = beat_q + 8'd1;
          if (beat_q + 8'd1 == 8'(BURST_LEN)) state_d = S_DRAIN;
        end else if (!g_valid && (beat_q != '0)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          done_d  = 1'b1;
          state_d = S_CMPLT;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          cmplt_d = 1'b1;
`ifndef BMP_ARB_FIXED_PRIO_EN
          rr_d    = (grant_q == GW'(NUM_SLV-1)) ? '0 : grant_q + GW'(1);
`endif
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
`ifndef BMP_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
      out_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      dtp_q   <= '0;
      pvld_q  <= 1'b0;
      mode_q  <= '0;
      dproc_q <= '0;
      done_q  <= 1'b0;
      cmplt_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifndef BMP_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      dtp_q   <= dtp_d;
      pvld_q  <= pvld_d;
      mode_q  <= mode_d;
      dproc_q <= dproc_d;
      done_q  <= done_d;
      cmplt_q <= cmplt_d;
      ovf_q   <= ovf_d;
      if (push) mem_q[wp_q] <= data_from_processor;
    end
  end

  assign data_to_processor    = dtp_q;
  assign scheduler_2_proc_vld = pvld_q;
  assign mode                 = mode_q;
  assign data_proc            = dproc_q;
  assign done                 = done_q;
  assign mstr0_cmplt          = cmplt_q;
  assign ovf_err              = ovf_q;
  assign mstr0_data_valid     = (cnt_q != '0);
  // Gate the head so an empty FIFO never shows stale or uninitialised storage.
  assign data_to_master       = (cnt_q != '0) ? mem_q[rp_q] : '0;

endmodule
